// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg
//   Shared types and widths for the simple_bus initiator.
//   mode_e  : bus_mode encoding (11 is reserved and never driven)
//   state_e : initiator FSM states
package simple_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_NOP   = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/simple_bus_wdog.sv
// simple_bus_wdog
//   Wait-cycle watchdog for the simple_bus initiator.
//   Ports:
//     clk     : clock
//     rst     : synchronous active-high reset
//     clr_i   : clear the count (state entry)
//     inc_i   : a waiting cycle is being spent
//     expired_o : this waiting cycle is the LIMIT-th one
module simple_bus_wdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= 8'd0;
        end else if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // cnt_q holds the number of earlier waiting cycles, so the current
    // cycle is the LIMIT-th one when cnt_q == LIMIT-1.
    assign expired_o = inc_i && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/simple_bus_initiator.sv
// simple_bus_initiator
//   Requester end of simple_bus. Takes one read/write command at a time,
//   arbitrates with bus_req/bus_gnt, issues a one-cycle bus_start with
//   addr/mode/data, waits for bus_ready and returns one response pulse.
//   Optional macro SIMPLE_BUS_INIT_TIMEOUT_EN adds a watchdog that turns
//   a TIMEOUT_CYCLES-long wait for gnt or ready into an error response.
//   Ports:
//     clk, rst                    : clock, synchronous active-high reset
//     cmd_valid/ready/write/addr/wdata : command side (valid/ready accept)
//     rsp_valid/rdata/err         : one-cycle response, no backpressure
//     bus_req/gnt                 : arbitration
//     bus_addr/mode/data_o/start  : transfer issue
//     bus_data_i/ready            : target read data and completion
//   All outputs come from registers or a decode of the state register.
module simple_bus_initiator
    import simple_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic [1:0]        bus_mode,
    output logic              bus_start,
    input  logic              bus_ready
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("simple_bus_initiator: TIMEOUT_CYCLES must be 2..255");
    end

    state_e            state_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              wdog_expired;

`ifdef SIMPLE_BUS_INIT_TIMEOUT_EN
    logic wdog_clr;
    logic wdog_inc;

    // Clear on the edges that enter REQ (accept) and WAIT (leaving START).
    assign wdog_clr = ((state_q == ST_IDLE) && cmd_valid) || (state_q == ST_START);
    assign wdog_inc = (state_q == ST_REQ) || (state_q == ST_WAIT);

    simple_bus_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wdog_clr),
        .inc_i     (wdog_inc),
        .expired_o (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        write_q <= cmd_write;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A grant arriving on the expiring cycle still wins.
                    if (bus_gnt) begin
                        state_q <= ST_START;
                    end else if (wdog_expired) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus_ready) begin
                        rdata_q <= write_q ? '0 : bus_data_i;
                        state_q <= ST_RESP;
                    end else if (wdog_expired) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    logic drive;
    assign drive = (state_q == ST_START) || (state_q == ST_WAIT);

    assign cmd_ready  = (state_q == ST_IDLE);
    assign bus_req    = (state_q == ST_REQ) || drive;
    assign bus_start  = (state_q == ST_START);
    assign bus_addr   = drive ? addr_q : '0;
    assign bus_mode   = drive ? (write_q ? MODE_WRITE : MODE_READ) : MODE_NOP;
    assign bus_data_o = (drive && write_q) ? wdata_q : '0;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_rdata  = (state_q == ST_RESP) ? rdata_q : '0;
    assign rsp_err    = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_simple_bus_initiator.sv
module tb_simple_bus_initiator;

    localparam int TB_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] bus_addr;
    logic [7:0] bus_data_o;
    logic [7:0] bus_data_i;
    logic [1:0] bus_mode;
    logic       bus_start;
    logic       bus_ready;

    simple_bus_initiator #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_addr   (bus_addr),
        .bus_data_o (bus_data_o),
        .bus_data_i (bus_data_i),
        .bus_mode   (bus_mode),
        .bus_start  (bus_start),
        .bus_ready  (bus_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] tdata;      // what the target returns on reads
        int         gdel;       // REQ cycles with gnt low
        int         rdel;       // WAIT cycles with ready low
        logic       start_rdy;  // ready value driven during START
        logic [7:0] exp_rdata;
        logic [1:0] exp_mode;
        logic [7:0] exp_data_o;
        int         exp_lat;    // accept edge to rsp_valid cycle
    } vec_t;

    typedef struct {
        logic       acc_ok;
        logic       got;
        logic [7:0] rdata;
        logic       err;
        int         lat;
        logic       req_at_rsp;
        int         starts;
        logic [7:0] addr;
        logic [1:0] mode;
        logic [7:0] data;
        int         req_cyc;
        int         unstable;
        logic       rsp_after;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tgt_mem [256];
    logic [7:0] ref_mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acts as both command source and bus target for one command.
    task automatic do_cmd(input vec_t v, input bit use_mem, output res_t r);
        int  cyc;
        int  wcyc;
        bit  started;
        r = '{default: 0};
        cyc = 0;
        wcyc = 0;
        started = 0;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_valid = 1'b1;
        bus_gnt   = 1'b0;
        bus_ready = 1'b0;
        r.acc_ok  = cmd_ready;
        while (cyc < 300 && !r.got) begin
            step();
            cyc++;
            cmd_valid  = 1'b0;
            bus_data_i = use_mem ? tgt_mem[bus_addr] : v.tdata;
            if (rsp_valid) begin
                r.got        = 1'b1;
                r.rdata      = rsp_rdata;
                r.err        = rsp_err;
                r.lat        = cyc;
                r.req_at_rsp = bus_req;
            end else if (bus_start) begin
                r.starts++;
                started   = 1;
                r.addr    = bus_addr;
                r.mode    = bus_mode;
                r.data    = bus_data_o;
                bus_ready = v.start_rdy;
                bus_gnt   = 1'($urandom_range(0, 1));
            end else if (bus_req && !started) begin
                r.req_cyc++;
                bus_gnt = (r.req_cyc > v.gdel);
            end else if (bus_req) begin
                wcyc++;
                if (bus_addr != r.addr || bus_mode != r.mode || bus_data_o != r.data)
                    r.unstable++;
                bus_ready = (wcyc > v.rdel);
                bus_gnt   = 1'($urandom_range(0, 1));
            end
        end
        bus_gnt   = 1'b0;
        bus_ready = 1'b0;
        if (r.got && r.mode == 2'b10)
            tgt_mem[r.addr] = r.data;
        step();
        r.rsp_after = rsp_valid;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input res_t r);
        check({tag, " accept"}, 32'(r.acc_ok), 32'd1);
        check({tag, " rsp_seen"}, 32'(r.got), 32'd1);
        check({tag, " rdata"}, 32'(r.rdata), 32'(v.exp_rdata));
        check({tag, " err"}, 32'(r.err), 32'd0);
        check({tag, " latency"}, 32'(r.lat), 32'(v.exp_lat));
        check({tag, " mode"}, 32'(r.mode), 32'(v.exp_mode));
        check({tag, " addr"}, 32'(r.addr), 32'(v.addr));
        check({tag, " data_o"}, 32'(r.data), 32'(v.exp_data_o));
        check({tag, " start_cnt"}, 32'(r.starts), 32'd1);
        check({tag, " req_cycles"}, 32'(r.req_cyc), 32'(v.gdel + 1));
        check({tag, " wait_stable"}, 32'(r.unstable), 32'd0);
        check({tag, " rsp_one_cycle"}, 32'(r.rsp_after), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " quiet"}, {bus_req, bus_start, bus_mode, rsp_valid, rsp_err, 26'd0}, 32'd0);
        check({tag, " buses"}, {8'd0, bus_addr, bus_data_o, rsp_rdata}, 32'd0);
    endtask

    vec_t tbl [5];
    res_t res;
    vec_t v;
    int   acc;
    int   nrsp;
    int   busy_rdy;
    int   rsp_cyc [8];
    int   stray;

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        bus_gnt = 1'b0; bus_ready = 1'b0; bus_data_i = '0;
        for (int i = 0; i < 256; i++) begin
            tgt_mem[i] = 8'((i * 37 + 11) & 255);
            ref_mem[i] = 8'((i * 37 + 11) & 255);
        end

        //        wr    addr   wdata  tdata  gd rd srdy  exp_rd exp_mode exp_do  lat
        tbl[0] = '{1'b0, 8'h3C, 8'h00, 8'hA5, 0, 0, 1'b0, 8'hA5, 2'b01, 8'h00, 4};
        tbl[1] = '{1'b1, 8'h10, 8'h5A, 8'h77, 4, 0, 1'b0, 8'h00, 2'b10, 8'h5A, 8};
        tbl[2] = '{1'b0, 8'h81, 8'h00, 8'hC3, 0, 3, 1'b1, 8'hC3, 2'b01, 8'h00, 7};
        tbl[3] = '{1'b1, 8'hFF, 8'hFF, 8'h12, 2, 2, 1'b1, 8'h00, 2'b10, 8'hFF, 8};
        tbl[4] = '{1'b0, 8'h00, 8'hEE, 8'hFF, 1, 1, 1'b0, 8'hFF, 2'b01, 8'h00, 6};

        // Reset state
        step();
        check_idle_outputs("reset");
        step();
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            do_cmd(tbl[i], 1'b0, res);
            check_vec($sformatf("vec%0d", i), tbl[i], res);
            $display("vec%0d wr=%0d addr=%02h rdata=%02h lat=%0d", i, tbl[i].wr, tbl[i].addr, res.rdata, res.lat);
        end

        // Back-to-back: cmd_valid held for three commands, gnt/ready high
        cmd_write = 1'b0; cmd_addr = 8'h20; cmd_valid = 1'b1;
        bus_gnt = 1'b1; bus_ready = 1'b1; bus_data_i = 8'h99;
        acc = 0; nrsp = 0; busy_rdy = 0;
        for (int c = 1; c <= 30; c++) begin
            if (cmd_valid && cmd_ready) acc++;
            step();
            if (acc == 3) cmd_valid = 1'b0;
            cmd_addr = 8'(8'h20 + acc);
            if (rsp_valid && nrsp < 8) begin
                rsp_cyc[nrsp] = c;
                nrsp++;
            end
            if (bus_req && cmd_ready) busy_rdy++;
        end
        bus_gnt = 1'b0; bus_ready = 1'b0;
        check("b2b rsp_count", 32'(nrsp), 32'd3);
        if (nrsp == 3) begin
            check("b2b first_lat", 32'(rsp_cyc[0]), 32'd4);
            check("b2b gap01", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd5);
            check("b2b gap12", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd5);
        end
        check("b2b ready_while_busy", 32'(busy_rdy), 32'd0);
        $display("b2b responses=%0d", nrsp);

        // Reset while in WAIT
        cmd_write = 1'b0; cmd_addr = 8'h42; cmd_valid = 1'b1;
        bus_gnt = 1'b1; bus_ready = 1'b0;
        step();            // REQ
        cmd_valid = 1'b0;
        step();            // START
        step();            // WAIT
        check("rstwait in_wait", {30'd0, bus_req, bus_start}, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_gnt = 1'b0;
        check_idle_outputs("rstwait");
        stray = 0;
        bus_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (rsp_valid) stray++;
        end
        bus_ready = 1'b0;
        check("rstwait no_rsp", 32'(stray), 32'd0);
        do_cmd(tbl[0], 1'b0, res);
        check_vec("after_rst", tbl[0], res);
        $display("reset-in-WAIT recovery rdata=%02h lat=%0d", res.rdata, res.lat);

        // Randomized commands against a memory reference model
        for (int i = 0; i < 40; i++) begin
            v.wr        = 1'($urandom_range(0, 1));
            v.addr      = 8'($urandom_range(0, 15));
            v.wdata     = 8'($urandom_range(0, 255));
            v.tdata     = 8'h00;
            v.gdel      = $urandom_range(0, 3);
            v.rdel      = $urandom_range(0, 3);
            v.start_rdy = 1'($urandom_range(0, 1));
            v.exp_rdata = v.wr ? 8'h00 : ref_mem[v.addr];
            v.exp_mode  = v.wr ? 2'b10 : 2'b01;
            v.exp_data_o = v.wr ? v.wdata : 8'h00;
            v.exp_lat   = 4 + v.gdel + v.rdel;
            if (v.wr) ref_mem[v.addr] = v.wdata;
            do_cmd(v, 1'b1, res);
            check($sformatf("rnd%0d rsp_seen", i), 32'(res.got), 32'd1);
            check($sformatf("rnd%0d rdata", i), 32'(res.rdata), 32'(v.exp_rdata));
            check($sformatf("rnd%0d err", i), 32'(res.err), 32'd0);
            check($sformatf("rnd%0d latency", i), 32'(res.lat), 32'(v.exp_lat));
            check($sformatf("rnd%0d mode", i), 32'(res.mode), 32'(v.exp_mode));
            check($sformatf("rnd%0d data_o", i), 32'(res.data), 32'(v.exp_data_o));
            $display("rnd%0d wr=%0d addr=%02h rdata=%02h lat=%0d", i, v.wr, v.addr, res.rdata, res.lat);
        end

`ifdef SIMPLE_BUS_INIT_TIMEOUT_EN
        // Grant never arrives: error response after TB_TIMEOUT REQ cycles
        v = tbl[0];
        v.gdel = 100000;
        do_cmd(v, 1'b0, res);
        check("tmo rsp_seen", 32'(res.got), 32'd1);
        check("tmo err", 32'(res.err), 32'd1);
        check("tmo rdata", 32'(res.rdata), 32'd0);
        check("tmo req_cycles", 32'(res.req_cyc), 32'(TB_TIMEOUT));
        check("tmo req_in_resp", 32'(res.req_at_rsp), 32'd0);
        check("tmo starts", 32'(res.starts), 32'd0);
        $display("timeout err=%0d req_cycles=%0d", res.err, res.req_cyc);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simple_bus_initiator.md
Name: simple_bus_initiator

Overview:
- Requester end of the simple_bus protocol, the counterpart of the grant/response side.
- Accepts single read/write commands from local logic and arbitrates with req/gnt.
- Issues addr/mode/data with a one-cycle start pulse, waits for ready, then returns one response (read data or error) per command.
- Sits between CPU-side command logic and a simple_bus memory/target.

Parameters:
- TIMEOUT_CYCLES, 16, wait-cycle limit for gnt or ready before an error response (used only with the optional feature). Legal range 2..255.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  8  target address
- cmd_wdata  input  8  write data
- rsp_valid  output  1  one-cycle response pulse; no backpressure
- rsp_rdata  output  8  read data; 0 for writes and errors
- rsp_err  output  1  response is a timeout error
- bus_req  output  1  bus request
- bus_gnt  input  1  bus grant
- bus_addr  output  8  bus address
- bus_data_o  output  8  write data to target
- bus_data_i  input  8  read data from target
- bus_mode  output  2  00 NOP, 01 READ, 10 WRITE, 11 reserved (never driven)
- bus_start  output  1  one-cycle transfer start
- bus_ready  input  1  target completion

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all outputs 0, except cmd_ready = 1 once the FSM is in IDLE. The FSM returns to IDLE.
- Reset mid-transaction: aborts the transaction; no rsp_valid is produced; bus_req drops on the next edge.
- FSM states: IDLE, REQ, START, WAIT, RESP. All outputs are registered or decoded from the state only; there is no combinational path from any input to any output.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch write/addr/wdata and go to REQ.
  - bus_mode = 00; bus_addr and bus_data_o = 0.
- REQ:
  - bus_req = 1; cmd_ready = 0.
  - When bus_gnt is sampled 1, go to START.
  - gnt low: stay in REQ.
- START:
  - bus_req = 1, bus_start = 1 for exactly this cycle.
  - bus_addr, bus_mode and bus_data_o are driven from the latched command; bus_data_o = 0 on reads.
  - Always go to WAIT; bus_ready is ignored in START.
- WAIT:
  - bus_req = 1, bus_start = 0; address, mode and data stay stable.
  - bus_gnt is ignored.
  - When bus_ready is sampled 1: capture bus_data_i for reads and go to RESP.
- RESP:
  - rsp_valid = 1 for one cycle; rsp_rdata is valid only this cycle.
  - bus_req = 0; bus_mode = 00.
  - Go to IDLE.
- Minimum latency (gnt and ready held high): accept at edge 0 → req visible in cycle 1 → START in cycle 2 → WAIT in cycle 3 → rsp_valid in cycle 4. Back-to-back throughput is therefore one command per 5 cycles.
- Simultaneous events: cmd_valid during a busy state is not accepted; the source holds it.

Optional Feature:
- Macro SIMPLE_BUS_INIT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and on entry to WAIT, and increments each cycle spent in those states.
  - If it reaches TIMEOUT_CYCLES without gnt (REQ) or ready (WAIT), go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - If the event arrives in the same cycle the count reaches the limit, the event wins (no error).
- Undefined: no counter; REQ and WAIT wait indefinitely; rsp_err is tied to 0.

Decomposition:
- Package simple_bus_pkg:
  - mode_e enum (NOP, READ, WRITE).
  - state_e enum for the FSM.
  - Localparams ADDR_W = 8, DATA_W = 8.
- One sub-module, simple_bus_wdog: the clear/increment/expire counter, instantiated only under SIMPLE_BUS_INIT_TIMEOUT_EN.

Test Plan:
- Read, gnt and ready tied high: cmd addr=0x3C read, target returns 0xA5 → bus_start one cycle with mode=01, addr=0x3C; rsp_valid 4 cycles after accept, rsp_rdata=0xA5, rsp_err=0.
- Write with gnt delayed 5 cycles: addr=0x10, wdata=0x5A → bus_req high for 5 REQ cycles; then start with mode=10, data_o=0x5A; rsp_valid with rsp_rdata=0.
- ready asserted in the START cycle, then deasserted for 3 cycles, then asserted: the START-cycle ready is ignored; completion follows the later ready; addr/mode are stable throughout WAIT.
- Back-to-back: cmd_valid held for 3 commands → exactly 3 rsp_valid pulses, 5 cycles apart; cmd_ready low while busy.
- Reset in WAIT: rst one cycle → all outputs 0 next cycle, no rsp_valid; next command completes normally.
- SIMPLE_BUS_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never asserted → rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 REQ cycles; bus_req drops in the RESP cycle.
